// File: rtl/snn_neuron_bank.sv
// snn_neuron_bank: integrate-and-fire neuron bank fed by the crossbar ADCs.
//
// Each accepted sample (EN=1, PD=0) adds one signed current per neuron into a
// saturating membrane, fires when the membrane reaches VTH and then subtracts
// VTH. FT starts a new output position at base 0. After T+1 timesteps the
// per-neuron spike counts are emitted with a one-cycle CNT_VALID pulse.
//
// Optional feature: define SNN_NEURON_LEAK_EN to add the LEAK port, which is
// subtracted on every accepted sample. Without it the leak term is zero.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   EN         integrate strobe
//   FT         first-timestep flag (qualified by EN)
//   PD         crossbar power-down, clears all state like RST
//   X          N signed samples, neuron k = X[k*IN_WIDTH +: IN_WIDTH]
//   T          timesteps per position minus one
//   VTH        positive firing threshold
//   LEAK       per-step leak (SNN_NEURON_LEAK_EN only)
//   SPK        spike vector, qualified by SPK_VALID
//   CNT        per-neuron spike counts, qualified by CNT_VALID pulse

module snn_neuron_bank #(
    parameter int unsigned N        = 8,
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned VM_WIDTH = 12,
    parameter int unsigned T_WIDTH  = 5
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    input  logic                        FT,
    input  logic                        PD,
    input  logic [N*IN_WIDTH-1:0]       X,
    input  logic [T_WIDTH-1:0]          T,
    input  logic [VM_WIDTH-1:0]         VTH,
`ifdef SNN_NEURON_LEAK_EN
    input  logic [VM_WIDTH-1:0]         LEAK,
`endif
    output logic [N-1:0]                SPK,
    output logic                        SPK_VALID,
    output logic [N*(T_WIDTH+1)-1:0]    CNT,
    output logic                        CNT_VALID
);

    localparam int unsigned SW = VM_WIDTH + 2;
    localparam int unsigned CW = T_WIDTH + 1;
    localparam logic signed [SW-1:0] VmMax = {3'b000, {(VM_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] VmMin = {3'b111, {(VM_WIDTH-1){1'b0}}};

    logic signed [VM_WIDTH-1:0] vm_q [N];
    logic signed [VM_WIDTH-1:0] vm_d [N];
    logic [CW-1:0]              cnt_q [N];
    logic [CW-1:0]              cnt_d [N];
    logic [T_WIDTH-1:0]         s_q, s_d;
    logic [N-1:0]               spk_q, spk_d;
    logic                       spk_valid_q, spk_valid_d;
    logic [N*CW-1:0]            cnt_out_q, cnt_out_d;
    logic                       cnt_valid_q, cnt_valid_d;

    logic signed [VM_WIDTH-1:0] leak;
    logic signed [VM_WIDTH-1:0] vth_s;
    logic [T_WIDTH-1:0]         cur;
    logic                       last;
    logic [N-1:0]               spike;
    logic signed [VM_WIDTH-1:0] vm_acc [N];
    logic [CW-1:0]              cnt_acc [N];

`ifdef SNN_NEURON_LEAK_EN
    assign leak = LEAK;
`else
    assign leak = '0;
`endif

    assign vth_s = VTH;
    assign cur   = FT ? '0 : s_q;
    // A sample at s==T without FT is also last, so the position wraps.
    assign last  = (cur == T);

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic signed [IN_WIDTH-1:0] x_k;
        logic signed [VM_WIDTH-1:0] base;
        logic signed [SW-1:0]       sum;
        logic signed [VM_WIDTH-1:0] sat;

        assign x_k  = X[k*IN_WIDTH +: IN_WIDTH];
        assign base = FT ? '0 : vm_q[k];
        // Two guard bits cover base + sample - leak before clamping.
        assign sum  = SW'(base) + SW'(x_k) - SW'(leak);
        assign sat  = (sum > VmMax) ? VmMax[VM_WIDTH-1:0] :
                      (sum < VmMin) ? VmMin[VM_WIDTH-1:0] : sum[VM_WIDTH-1:0];
        assign spike[k]   = (sat >= vth_s);
        assign vm_acc[k]  = spike[k] ? sat - vth_s : sat;
        assign cnt_acc[k] = (FT ? '0 : cnt_q[k]) + CW'(spike[k]);
    end

    always_comb begin
        vm_d        = vm_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        spk_d       = spk_q;
        spk_valid_d = 1'b0;
        cnt_out_d   = cnt_out_q;
        cnt_valid_d = 1'b0;
        if (PD) begin
            for (int k = 0; k < N; k++) begin
                vm_d[k]  = '0;
                cnt_d[k] = '0;
            end
            s_d       = '0;
            spk_d     = '0;
            cnt_out_d = '0;
        end else if (EN) begin
            for (int k = 0; k < N; k++) begin
                vm_d[k] = vm_acc[k];
                if (last) begin
                    cnt_d[k]                = '0;
                    cnt_out_d[k*CW +: CW]   = cnt_acc[k];
                end else begin
                    cnt_d[k] = cnt_acc[k];
                end
            end
            spk_d       = spike;
            spk_valid_d = 1'b1;
            cnt_valid_d = last;
            s_d         = last ? '0 : cur + T_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N; k++) begin
                vm_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
            s_q         <= '0;
            spk_q       <= '0;
            spk_valid_q <= 1'b0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            vm_q        <= vm_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            spk_q       <= spk_d;
            spk_valid_q <= spk_valid_d;
            cnt_out_q   <= cnt_out_d;
            cnt_valid_q <= cnt_valid_d;
        end
    end

    assign SPK       = spk_q;
    assign SPK_VALID = spk_valid_q;
    assign CNT       = cnt_out_q;
    assign CNT_VALID = cnt_valid_q;

endmodule
